// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        RUN        = 2'd1,
        HALT       = 2'd2
    } state_t;

    localparam int PC_WIDTH_DEF = 16;
    localparam int PC_STEP_DEF  = 2;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-control bundle between the PC generator (slave) and its driver (master).
interface pc_gen_if
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH_DEF
);

    logic             stall;
    logic             br_valid;
    logic [WIDTH-1:0] br_target;
    logic             hlt;
    logic             resume;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic             pc_valid;
    logic             redirect_pending;
    logic             halted;

    modport master (
        output stall, br_valid, br_target, hlt, resume,
        input  pc, pc_plus, pc_valid, redirect_pending, halted
    );

    modport slave (
        input  stall, br_valid, br_target, hlt, resume,
        output pc, pc_plus, pc_valid, redirect_pending, halted
    );

endinterface

// File: rtl/pc_incr.sv
// Constant-step incrementer: 4-bit carry-lookahead groups joined by a group carry chain.
module pc_incr
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH_DEF,
    parameter int STEP  = PC_STEP_DEF
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum
);

    localparam int               NG = WIDTH / 4;
    localparam logic [WIDTH-1:0] B  = WIDTH'(STEP);

    for (genvar k = 0; k < NG; k++) begin : grp
        logic [3:0] g, p, c;
        logic       cin, cout;

        assign g = a[4*k +: 4] & B[4*k +: 4];
        assign p = a[4*k +: 4] ^ B[4*k +: 4];

        if (k == 0) begin : g_first
            assign cin = 1'b0;
        end else begin : g_chain
            assign cin = grp[k-1].cout;
        end

        assign c = {g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin),
                    g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin),
                    g[0] | (p[0] & cin),
                    cin};

        assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & cin);

        assign sum[4*k +: 4] = p ^ c;
    end

    // Carry out of the top group is discarded: the PC wraps modulo 2^WIDTH.
    logic carry_unused;
    assign carry_unused = grp[NG-1].cout;

endmodule

// File: rtl/pc_gen.sv
// Registered fetch PC with branch redirect, one-entry stalled-redirect buffer and halt/resume FSM.
module pc_gen
    import pc_pkg::*;
#(
    parameter int               WIDTH     = PC_WIDTH_DEF,
    parameter int               STEP      = PC_STEP_DEF,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.slave   bus
);

    state_t           state, state_n;
    logic [WIDTH-1:0] pc_q, pc_n, pc_plus;
    logic             buf_valid, buf_valid_n;
    logic [WIDTH-1:0] buf_addr, buf_addr_n;

    pc_incr #(.WIDTH(WIDTH), .STEP(STEP)) u_incr (
        .a   (pc_q),
        .sum (pc_plus)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RESET_WAIT;
            pc_q      <= RESET_VEC;
            buf_valid <= 1'b0;
            buf_addr  <= '0;
        end else begin
            state     <= state_n;
            pc_q      <= pc_n;
            buf_valid <= buf_valid_n;
            buf_addr  <= buf_addr_n;
        end
    end

    always_comb begin
        // NOTE: every output gets a hold default first so no path through the case can infer a latch.
        state_n     = state;
        pc_n        = pc_q;
        buf_valid_n = buf_valid;
        buf_addr_n  = buf_addr;

        unique case (state)
            RESET_WAIT: state_n = RUN;
            RUN: begin
                if (bus.stall) begin
                    if (bus.br_valid) begin
                        buf_valid_n = 1'b1;
                        buf_addr_n  = bus.br_target;
                    end
                end else if (buf_valid) begin
                    // The buffered branch is older than any live one, so a live br_valid is dropped.
                    pc_n        = buf_addr;
                    buf_valid_n = 1'b0;
                end else if (bus.br_valid) begin
                    pc_n = bus.br_target;
                end else if (bus.hlt) begin
                    state_n = HALT;
                end else begin
                    pc_n = pc_plus;
                end
            end
            HALT: begin
                if (bus.resume) state_n = RUN;
            end
            default: state_n = RESET_WAIT;
        endcase
    end

    assign bus.pc               = pc_q;
    assign bus.pc_plus          = pc_plus;
    assign bus.pc_valid         = (state == RUN);
    assign bus.halted           = (state == HALT);
    assign bus.redirect_pending = buf_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a 16-bit instance for the main sequence and a 32-bit/STEP=4 instance for reset-mid-operation.
module tb_pc_gen;

    logic clk = 1'b0;
    logic rst16, rst32;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_gen_if #(.WIDTH(16)) bus16 ();
    pc_gen_if #(.WIDTH(32)) bus32 ();

    pc_gen #(.WIDTH(16), .STEP(2), .RESET_VEC(16'h0100)) dut16 (
        .clk (clk),
        .rst (rst16),
        .bus (bus16)
    );

    pc_gen #(.WIDTH(32), .STEP(4), .RESET_VEC(32'h0)) dut32 (
        .clk (clk),
        .rst (rst32),
        .bus (bus32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk16(input string tag, input logic [15:0] pc, input logic valid,
                         input logic halted, input logic pending);
        check({tag, ".pc"}, 32'(bus16.pc), 32'(pc));
        check({tag, ".pc_valid"}, 32'(bus16.pc_valid), 32'(valid));
        check({tag, ".halted"}, 32'(bus16.halted), 32'(halted));
        check({tag, ".pending"}, 32'(bus16.redirect_pending), 32'(pending));
    endtask

    initial begin
        rst16 = 1'b1;
        rst32 = 1'b1;
        bus16.stall = 0; bus16.br_valid = 0; bus16.br_target = '0; bus16.hlt = 0; bus16.resume = 0;
        bus32.stall = 0; bus32.br_valid = 0; bus32.br_target = '0; bus32.hlt = 0; bus32.resume = 0;

        // Reset and sequential run
        #1;
        chk16("rst", 16'h0100, 0, 0, 0);
        check("rst.pc_plus", 32'(bus16.pc_plus), 32'h0102);
        step();
        rst16 = 1'b0;
        step(); chk16("seq0", 16'h0100, 1, 0, 0);
        step(); chk16("seq1", 16'h0102, 1, 0, 0);
        step(); chk16("seq2", 16'h0104, 1, 0, 0);
        step(); chk16("seq3", 16'h0106, 1, 0, 0);

        // Wrap through 0xFFFF
        bus16.br_valid = 1; bus16.br_target = 16'hFFFC;
        step(); chk16("wrap0", 16'hFFFC, 1, 0, 0);
        bus16.br_valid = 0;
        check("wrap0.pc_plus", 32'(bus16.pc_plus), 32'hFFFE);
        step(); check("wrap1.pc", 32'(bus16.pc), 32'hFFFE);
        check("wrap1.pc_plus", 32'(bus16.pc_plus), 32'h0000);
        step(); check("wrap2.pc", 32'(bus16.pc), 32'h0000);
        step(); check("wrap3.pc", 32'(bus16.pc), 32'h0002);

        // Stalled redirect: second capture overwrites, live branch at release is dropped
        bus16.stall = 1; bus16.br_valid = 1; bus16.br_target = 16'h0040;
        step(); chk16("stall0", 16'h0002, 1, 0, 1);
        bus16.br_target = 16'h0080;
        step(); chk16("stall1", 16'h0002, 1, 0, 1);
        bus16.stall = 0; bus16.br_target = 16'h00C0;
        step(); chk16("release", 16'h0080, 1, 0, 0);
        bus16.br_valid = 0;
        step(); chk16("release+1", 16'h0082, 1, 0, 0);

        // Halt / resume with br_valid and stall ignored while halted
        bus16.br_valid = 1; bus16.br_target = 16'h0010;
        step(); check("pre_halt.pc", 32'(bus16.pc), 32'h0010);
        bus16.br_valid = 0; bus16.hlt = 1;
        step(); chk16("halt0", 16'h0010, 0, 1, 0);
        bus16.hlt = 0; bus16.br_target = 16'h0300;
        for (int i = 0; i < 3; i++) begin
            bus16.br_valid = (i % 2 == 0);
            bus16.stall    = (i == 1);
            step(); chk16($sformatf("halt%0d", i + 1), 16'h0010, 0, 1, 0);
        end
        bus16.br_valid = 0; bus16.stall = 0; bus16.resume = 1;
        step(); chk16("resume0", 16'h0010, 1, 0, 0);
        bus16.resume = 0;
        step(); chk16("resume1", 16'h0012, 1, 0, 0);

        // Simultaneous hlt and br_valid: the branch wins, no halt
        bus16.br_valid = 1; bus16.br_target = 16'h0020;
        step(); check("pre_both.pc", 32'(bus16.pc), 32'h0020);
        bus16.hlt = 1; bus16.br_target = 16'h0200;
        step(); chk16("both", 16'h0200, 1, 0, 0);
        bus16.hlt = 0; bus16.br_valid = 0;
        step(); chk16("both+1", 16'h0202, 1, 0, 0);

        // 32-bit, STEP=4: asynchronous reset with a pending redirect
        rst32 = 1'b0;
        step(); check("w32.start.pc", bus32.pc, 32'h0);
        check("w32.start.valid", 32'(bus32.pc_valid), 32'h1);
        bus32.br_valid = 1; bus32.br_target = 32'hFFFF_FFFC;
        step(); check("w32.top.pc", bus32.pc, 32'hFFFF_FFFC);
        check("w32.top.pc_plus", bus32.pc_plus, 32'h0);
        bus32.stall = 1; bus32.br_target = 32'h1234_5678;
        step(); check("w32.pending", 32'(bus32.redirect_pending), 32'h1);
        check("w32.held.pc", bus32.pc, 32'hFFFF_FFFC);
        #2;
        rst32 = 1'b1;
        #1;
        check("w32.arst.pc", bus32.pc, 32'h0);
        check("w32.arst.pending", 32'(bus32.redirect_pending), 32'h0);
        check("w32.arst.valid", 32'(bus32.pc_valid), 32'h0);
        check("w32.arst.halted", 32'(bus32.halted), 32'h0);
        bus32.stall = 0; bus32.br_valid = 0;
        step();
        rst32 = 1'b0;
        step(); check("w32.r0.pc", bus32.pc, 32'h0);
        check("w32.r0.valid", 32'(bus32.pc_valid), 32'h1);
        step(); check("w32.r1.pc", bus32.pc, 32'h4);
        step(); check("w32.r2.pc", bus32.pc, 32'h8);
        check("w32.r2.pending", 32'(bus32.redirect_pending), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
